// File: rtl/pipeline_sequencer.sv
// Stall/flush controller for the 5-stage pipeline.
// Drives the enable/nop pair of every pipeline latch and the PC enable from
// cache status, load-use detection, branch redirect and halt reaching MEM.
// Latch controls are combinational from state and inputs. A halt-drain FSM
// retires the halt and then freezes the pipeline. Saturating perf counters
// track stall and flush activity.
// Ports:
//   CLK, nRST                 clock (rising edge), async active-low reset
//   ihit, dhit, dmem_req      cache status / pending data access in EX/MEM
//   idex_memread, idex_wsel   load in ID/EX and its destination register
//   ifid_rs, ifid_rt          source registers of the IF/ID instruction
//   redirect, halt_mem        taken branch/jump in EX/MEM, halt in EX/MEM
//   pc_en, *_en, *_nop        PC enable and latch enable/bubble controls
//   halted                    sticky: pipeline drained after HALT
//   stall_cnt, flush_cnt      saturating performance counters
module pipeline_sequencer #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned REG_W = 5
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmem_req,
    input  logic             idex_memread,
    input  logic [REG_W-1:0] idex_wsel,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             redirect,
    input  logic             halt_mem,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_nop,
    output logic             idex_en,
    output logic             idex_nop,
    output logic             exmem_en,
    output logic             exmem_nop,
    output logic             memwb_en,
    output logic             memwb_nop,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       load_use;
    logic       mem_stall;
    logic       stall_inc;
    logic       flush_inc;

    assign load_use  = idex_memread && (idex_wsel != '0) &&
                       ((idex_wsel == ifid_rs) || (idex_wsel == ifid_rt));
    assign mem_stall = dmem_req && !dhit;

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= S_RUN;
        else       state <= state_next;
    end

    // Next state and latch controls
    always_comb begin
        state_next = state;
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_nop   = 1'b0;
        idex_en    = 1'b0;
        idex_nop   = 1'b0;
        exmem_en   = 1'b0;
        exmem_nop  = 1'b0;
        memwb_en   = 1'b0;
        memwb_nop  = 1'b0;
        halted     = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        case (state)
            S_RUN: begin
                if (mem_stall) begin
                    // full freeze: everything keeps its contents
                end else if (redirect) begin
                    pc_en     = 1'b1;
                    ifid_en   = 1'b1;
                    ifid_nop  = 1'b1;
                    idex_en   = 1'b1;
                    idex_nop  = 1'b1;
                    exmem_en  = 1'b1;
                    exmem_nop = 1'b1;
                    memwb_en  = 1'b1;
                    // a halt in MEM takes precedence over counting the flush
                    flush_inc = !halt_mem;
                end else if (load_use) begin
                    idex_en   = 1'b1;
                    idex_nop  = 1'b1;
                    exmem_en  = 1'b1;
                    memwb_en  = 1'b1;
                end else if (!ihit) begin
                    ifid_en   = 1'b1;
                    ifid_nop  = 1'b1;
                    idex_en   = 1'b1;
                    exmem_en  = 1'b1;
                    memwb_en  = 1'b1;
                end else begin
                    pc_en     = 1'b1;
                    ifid_en   = 1'b1;
                    idex_en   = 1'b1;
                    exmem_en  = 1'b1;
                    memwb_en  = 1'b1;
                end
                stall_inc = !pc_en;
                // halt moves into MEM/WB on this edge unless the data side is frozen
                if (halt_mem && !mem_stall) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                ifid_en    = 1'b1;
                ifid_nop   = 1'b1;
                idex_en    = 1'b1;
                idex_nop   = 1'b1;
                exmem_en   = 1'b1;
                exmem_nop  = 1'b1;
                memwb_en   = 1'b1;
                state_next = S_HALTED;
            end
            default: begin
                halted     = 1'b1;
                state_next = S_HALTED;
            end
        endcase
    end

    // Saturating performance counters, only advance while running
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: a table of single-cycle
// control vectors plus directed multi-cycle sequences (stall, flush, halt,
// counter saturation, async reset out of HALTED).
module tb_pipeline_sequencer;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned REG_W = 5;

    // {pc_en, ifid_en, ifid_nop, idex_en, idex_nop, exmem_en, exmem_nop, memwb_en, memwb_nop}
    localparam logic [8:0] P_RUN    = 9'b1_10_10_10_10;
    localparam logic [8:0] P_FREEZE = 9'b0_00_00_00_00;
    localparam logic [8:0] P_FLUSH  = 9'b1_11_11_11_10;
    localparam logic [8:0] P_LU     = 9'b0_00_11_10_10;
    localparam logic [8:0] P_IMISS  = 9'b0_11_10_10_10;
    localparam logic [8:0] P_DRAIN  = 9'b0_11_11_11_10;
    localparam logic [8:0] P_HALTED = 9'b0_00_00_00_00;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             ihit, dhit, dmem_req, idex_memread, redirect, halt_mem;
    logic [REG_W-1:0] idex_wsel, ifid_rs, ifid_rt;
    logic             pc_en, ifid_en, ifid_nop, idex_en, idex_nop;
    logic             exmem_en, exmem_nop, memwb_en, memwb_nop, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    pipeline_sequencer #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
        .CLK(CLK), .nRST(nRST),
        .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
        .idex_memread(idex_memread), .idex_wsel(idex_wsel),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .redirect(redirect), .halt_mem(halt_mem),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_nop(ifid_nop),
        .idex_en(idex_en), .idex_nop(idex_nop),
        .exmem_en(exmem_en), .exmem_nop(exmem_nop),
        .memwb_en(memwb_en), .memwb_nop(memwb_nop),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        string            name;
        logic             ihit, dhit, dmem_req, memread, redirect;
        logic [REG_W-1:0] wsel, rs, rt;
        logic [8:0]       exp;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [8:0] outs();
        return {pc_en, ifid_en, ifid_nop, idex_en, idex_nop,
                exmem_en, exmem_nop, memwb_en, memwb_nop};
    endfunction

    task automatic chk_pat(input string name, input logic [8:0] exp);
        n_cmp++;
        if (outs() !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, outs(), exp);
        end
    endtask

    task automatic chk_val(input string name, input logic [CNT_W-1:0] got,
                           input logic [CNT_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic set_in(input logic ih, input logic dh, input logic dr,
                          input logic mr, input logic [REG_W-1:0] ws,
                          input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                          input logic rd, input logic hm);
        ihit = ih; dhit = dh; dmem_req = dr; idex_memread = mr;
        idex_wsel = ws; ifid_rs = rs; ifid_rt = rt; redirect = rd; halt_mem = hm;
    endtask

    task automatic set_clean();
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        set_clean();
        #2;
        nRST = 1'b1;
    endtask

    task automatic add_vec(input int i, input string nm, input logic ih, input logic dh,
                           input logic dr, input logic mr, input logic [REG_W-1:0] ws,
                           input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                           input logic rd, input logic [8:0] exp);
        vecs[i].name = nm; vecs[i].ihit = ih; vecs[i].dhit = dh; vecs[i].dmem_req = dr;
        vecs[i].memread = mr; vecs[i].wsel = ws; vecs[i].rs = rs; vecs[i].rt = rt;
        vecs[i].redirect = rd; vecs[i].exp = exp;
    endtask

    initial begin
        nRST = 1'b0;
        set_clean();

        //         name            ih dh dr mr ws rs rt rd  expected
        add_vec(0,  "v_clean",      1, 1, 0, 0, 0, 0, 0, 0, P_RUN);
        add_vec(1,  "v_dmiss_noreq",1, 0, 0, 0, 0, 0, 0, 0, P_RUN);
        add_vec(2,  "v_memstall",   1, 0, 1, 0, 0, 0, 0, 0, P_FREEZE);
        add_vec(3,  "v_dreq_hit",   1, 1, 1, 0, 0, 0, 0, 0, P_RUN);
        add_vec(4,  "v_lu_rt",      1, 1, 0, 1, 5, 0, 5, 0, P_LU);
        add_vec(5,  "v_lu_rs",      1, 1, 0, 1, 5, 5, 2, 0, P_LU);
        add_vec(6,  "v_lu_r0",      1, 1, 0, 1, 0, 0, 0, 0, P_RUN);
        add_vec(7,  "v_lu_nomatch", 1, 1, 0, 1, 5, 3, 4, 0, P_RUN);
        add_vec(8,  "v_noload",     1, 1, 0, 0, 5, 5, 5, 0, P_RUN);
        add_vec(9,  "v_imiss",      0, 1, 0, 0, 0, 0, 0, 0, P_IMISS);
        add_vec(10, "v_redir_prio", 0, 1, 0, 1, 5, 0, 5, 1, P_FLUSH);
        add_vec(11, "v_stall_redir",1, 0, 1, 0, 0, 0, 0, 1, P_FREEZE);
        add_vec(12, "v_lu_imiss",   0, 1, 0, 1, 7, 7, 0, 0, P_LU);
        add_vec(13, "v_stall_imiss",0, 0, 1, 0, 0, 0, 0, 0, P_FREEZE);

        // Reset state
        #3;
        chk_pat("rst_outs", P_RUN);
        chk_val("rst_halted", CNT_W'(halted), '0);
        chk_val("rst_stall", stall_cnt, '0);
        chk_val("rst_flush", flush_cnt, '0);
        do_reset();

        // Single-cycle vector table
        for (int i = 0; i < 14; i++) begin
            @(negedge CLK);
            set_in(vecs[i].ihit, vecs[i].dhit, vecs[i].dmem_req, vecs[i].memread,
                   vecs[i].wsel, vecs[i].rs, vecs[i].rt, vecs[i].redirect, 1'b0);
            #1;
            chk_pat(vecs[i].name, vecs[i].exp);
        end

        // Clean stream for 10 cycles
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            set_clean();
            #1;
            chk_pat("clean_stream", P_RUN);
        end
        chk_val("clean_stall_cnt", stall_cnt, '0);

        // Three-cycle data miss, then advance
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            set_in(1, 0, 1, 0, 0, 0, 0, 0, 0);
            #1;
            chk_pat("dmiss_freeze", P_FREEZE);
        end
        @(negedge CLK);
        set_in(1, 1, 1, 0, 0, 0, 0, 0, 0);
        #1;
        chk_pat("dmiss_release", P_RUN);
        chk_val("dmiss_stall_cnt", stall_cnt, CNT_W'(3));
        @(negedge CLK);
        chk_val("dmiss_stall_after", stall_cnt, CNT_W'(3));

        // Redirect over imiss + load-use
        do_reset();
        @(negedge CLK);
        set_in(0, 1, 0, 1, 5, 0, 5, 1, 0);
        #1;
        chk_pat("flush_pat", P_FLUSH);
        @(negedge CLK);
        set_clean();
        #1;
        chk_val("flush_cnt1", flush_cnt, CNT_W'(1));
        chk_val("flush_stall0", stall_cnt, '0);

        // Halt with coincident redirect: drain, then halted forever
        do_reset();
        @(negedge CLK);
        set_in(1, 1, 0, 0, 0, 0, 0, 1, 1);
        @(negedge CLK);
        set_in(0, 1, 0, 1, 5, 5, 0, 1, 0);
        #1;
        chk_pat("drain_pat", P_DRAIN);
        chk_val("drain_halted", CNT_W'(halted), '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            set_in(1'(i), 0, 1, 0, 0, 0, 0, 1'(i), 1);
            #1;
            chk_pat("halted_pat", P_HALTED);
            chk_val("halted_flag", CNT_W'(halted), CNT_W'(1));
        end
        chk_val("halt_no_flush", flush_cnt, '0);
        chk_val("halt_no_stall", stall_cnt, '0);

        // Halt blocked by a data miss stays in RUN
        do_reset();
        @(negedge CLK);
        set_in(1, 0, 1, 0, 0, 0, 0, 0, 1);
        @(negedge CLK);
        set_in(1, 1, 1, 0, 0, 0, 0, 0, 0);
        #1;
        chk_pat("halt_stalled_run", P_RUN);

        // Stall counter saturation
        do_reset();
        @(negedge CLK);
        force dut.stall_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cnt;
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) @(negedge CLK);
        #1;
        chk_val("stall_sat", stall_cnt, '1);

        // Reach HALTED, then asynchronous reset mid-cycle
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 1);
        @(negedge CLK);
        set_clean();
        @(negedge CLK);
        #1;
        chk_val("pre_rst_halted", CNT_W'(halted), CNT_W'(1));
        #1;
        nRST = 1'b0;
        #1;
        chk_pat("async_rst_outs", P_RUN);
        chk_val("async_rst_halted", CNT_W'(halted), '0);
        chk_val("async_rst_stall", stall_cnt, '0);
        nRST = 1'b1;
        @(negedge CLK);
        #1;
        chk_pat("post_rst_run", P_RUN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
